// File: rtl/mac_tap_sequencer.sv
// Sequences one multiply-accumulate unit through a TAPS-long dot product and
// returns the final sum over a valid/ready handshake.
module mac_tap_sequencer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TAPS       = 9,
    parameter int unsigned AW         = $clog2(TAPS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bias_i,
    output logic                  busy,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0] win_rdata,
    input  logic [DATA_WIDTH-1:0] wt_rdata,
    output logic                  unit_en,
    output logic [DATA_WIDTH-1:0] unit_data,
    output logic [DATA_WIDTH-1:0] unit_weight,
    output logic [DATA_WIDTH-1:0] unit_bias,
    input  logic [DATA_WIDTH-1:0] unit_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  rd_en_nxt;
    logic [AW-1:0]         rd_addr_nxt;
    logic                  busy_nxt;
    logic                  out_valid_nxt;
    logic                  bias_load;
    logic                  v_d;
    logic                  first_d;
    logic [DATA_WIDTH-1:0] bias_reg;

    // Next-state and next-output decode
    always_comb begin
        state_nxt     = state;
        rd_en_nxt     = rd_en;
        rd_addr_nxt   = rd_addr;
        busy_nxt      = busy;
        out_valid_nxt = out_valid;
        bias_load     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    bias_load   = 1'b1;
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = '0;
                    busy_nxt    = 1'b1;
                    state_nxt   = RUN;
                end
            end
            RUN: begin
                if (rd_addr == LAST_ADDR) begin
                    rd_en_nxt = 1'b0;
                    state_nxt = DRAIN;
                end else begin
                    rd_addr_nxt = rd_addr + AW'(1);
                end
            end
            DRAIN: begin
                // Last tap is in the unit this cycle; its sum lands on the next edge
                if (v_d) begin
                    out_valid_nxt = 1'b1;
                    state_nxt     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            v_d       <= 1'b0;
            first_d   <= 1'b0;
            bias_reg  <= '0;
        end else begin
            state     <= state_nxt;
            rd_en     <= rd_en_nxt;
            rd_addr   <= rd_addr_nxt;
            busy      <= busy_nxt;
            out_valid <= out_valid_nxt;
            v_d       <= rd_en;
            first_d   <= rd_en && (rd_addr == '0);
            if (bias_load) begin
                bias_reg <= bias_i;
            end
        end
    end

    // Memory-latency-aligned unit drive; unit_result chains back as the running sum
    assign unit_en     = v_d;
    assign unit_data   = win_rdata;
    assign unit_weight = wt_rdata;
    assign unit_bias   = first_d ? bias_reg : unit_result;
    assign out_data    = unit_result;

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// Randomized scoreboard bench for mac_tap_sequencer with memory and unit models.
module tb_mac_tap_sequencer;

    localparam int unsigned DW   = 16;
    localparam int unsigned TAPS = 9;
    localparam int unsigned AW   = $clog2(TAPS);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] bias_i;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] win_rdata;
    logic [DW-1:0] wt_rdata;
    logic          unit_en;
    logic [DW-1:0] unit_data;
    logic [DW-1:0] unit_weight;
    logic [DW-1:0] unit_bias;
    logic [DW-1:0] unit_result;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    logic [DW-1:0] win_mem [TAPS];
    logic [DW-1:0] wt_mem  [TAPS];
    logic [DW-1:0] exp_q [$];

    int checks   = 0;
    int failures = 0;

    mac_tap_sequencer #(.DATA_WIDTH(DW), .TAPS(TAPS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias_i(bias_i), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .win_rdata(win_rdata), .wt_rdata(wt_rdata),
        .unit_en(unit_en), .unit_data(unit_data), .unit_weight(unit_weight),
        .unit_bias(unit_bias), .unit_result(unit_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Window/weight memories: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            win_rdata <= win_mem[rd_addr];
            wt_rdata  <= wt_mem[rd_addr];
        end
    end

    // MAC unit: registered bias + data*weight, never reset
    always @(posedge clk) begin
        if (unit_en) unit_result <= unit_bias + DW'(unit_data * unit_weight);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops on every handshake, checks hold stability
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always @(negedge clk) begin
        logic [DW-1:0] exp_v;
        #2;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (prev_valid && !prev_ready) check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_rd_en", 32'(rd_en), 32'(0));
                check("hold_unit_en", 32'(unit_en), 32'(0));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got %0h expected none", out_data);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("out_data", 32'(out_data), 32'(exp_v));
                    end
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) step();
        check("wait_idle", 32'(busy), 32'(0));
    endtask

    // pat: 0 random, 1 win=1/wt=1..TAPS, 2 all 0x0100
    task automatic load_mems(input int pat, input logic [DW-1:0] bias, output logic [DW-1:0] exp);
        int unsigned acc;
        acc = 32'(bias);
        for (int k = 0; k < TAPS; k++) begin
            case (pat)
                1:       begin win_mem[k] = 16'd1;      wt_mem[k] = DW'(k + 1); end
                2:       begin win_mem[k] = 16'h0100;   wt_mem[k] = 16'h0100;   end
                default: begin win_mem[k] = DW'($urandom); wt_mem[k] = DW'($urandom); end
            endcase
            acc += 32'(win_mem[k]) * 32'(wt_mem[k]);
        end
        exp = DW'(acc);
    endtask

    task automatic do_job(input int pat, input logic [DW-1:0] bias, input int ready_wait,
                          input bit start_on_hs);
        logic [DW-1:0] exp;
        int            n;
        bit            seen;
        wait_idle();
        load_mems(pat, bias, exp);
        exp_q.push_back(exp);
        bias_i    = bias;
        start     = 1'b1;
        out_ready = (ready_wait == 0);
        step();
        start = 1'b0;
        check("accept_busy", 32'(busy), 32'(1));
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            check("rd_en_seq", 32'(rd_en), 32'(n < TAPS));
            if (n < TAPS) check("rd_addr_seq", 32'(rd_addr), 32'(n));
            check("unit_en_seq", 32'(unit_en), 32'(n >= 1 && n <= TAPS));
            step();
            n++;
        end
        check("out_valid_seen", 32'(seen), 32'(1));
        check("latency", 32'(n), 32'(TAPS + 1));
        for (int i = 0; i < ready_wait; i++) begin
            start = ((i % 2) == 0);
            step();
            check("hold_busy", 32'(busy), 32'(1));
            check("hold_valid", 32'(out_valid), 32'(1));
        end
        out_ready = 1'b1;
        start     = start_on_hs;
        step();
        check("hs_busy", 32'(busy), 32'(0));
        check("hs_valid", 32'(out_valid), 32'(0));
    endtask

    task automatic reset_mid_job();
        logic [DW-1:0] unused_exp;
        wait_idle();
        load_mems(1, 16'd5, unused_exp);
        bias_i = 16'd5;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && rd_addr != AW'(4); i++) step();
        check("reached_tap4", 32'(rd_addr), 32'(4));
        rst_n = 1'b0;
        #1;
        check("rst_rd_en", 32'(rd_en), 32'(0));
        check("rst_rd_addr", 32'(rd_addr), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_unit_en", 32'(unit_en), 32'(0));
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < TAPS + 3; i++) begin
            step();
            check("abandoned_no_valid", 32'(out_valid), 32'(0));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        bias_i    = '0;
        for (int k = 0; k < TAPS; k++) begin
            win_mem[k] = '0;
            wt_mem[k]  = '0;
        end
        repeat (3) step();
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_rd_en", 32'(rd_en), 32'(0));
        check("reset_rd_addr", 32'(rd_addr), 32'(0));
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_unit_en", 32'(unit_en), 32'(0));
        rst_n = 1'b1;
        step();

        do_job(1, 16'd5, 0, 1'b0);
        do_job(1, 16'd5, 5, 1'b0);
        do_job(2, 16'd3, 0, 1'b0);
        reset_mid_job();
        do_job(1, 16'd5, 0, 1'b0);
        for (int j = 0; j < 4; j++) do_job(0, DW'($urandom), 0, 1'b1);
        do_job(0, DW'($urandom), 0, 1'b0);
        for (int j = 0; j < 4; j++) do_job(0, DW'($urandom), int'($urandom_range(0, 4)), 1'b0);

        repeat (4) step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
